// File: rtl/enigma_pkg.sv
// Shared Enigma rotor definitions: alphabet constants, wiring tables, notch positions
// and mod-26 letter helpers used by the rotor stages.
package enigma_pkg;

    localparam int LETTERS = 26;
    localparam int POS_W   = 5;
    localparam logic [POS_W-1:0] LETTERS_W = POS_W'(LETTERS);

    typedef enum logic [1:0] {
        CFG_ROTOR_I   = 2'b00,
        CFG_ROTOR_II  = 2'b01,
        CFG_ROTOR_III = 2'b10,
        CFG_NONE      = 2'b11
    } cfg_e;

    typedef struct packed {
        logic             valid;
        logic [POS_W-1:0] idx;
    } letter_t;

    localparam logic [POS_W-1:0] NOTCH_I   = 5'd17;
    localparam logic [POS_W-1:0] NOTCH_II  = 5'd5;
    localparam logic [POS_W-1:0] NOTCH_III = 5'd22;

    localparam logic [POS_W-1:0] FWD_I [LETTERS] = '{
        5'd4, 5'd10, 5'd12, 5'd5, 5'd11, 5'd6, 5'd3, 5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
        5'd22, 5'd24, 5'd7, 5'd23, 5'd20, 5'd18, 5'd15, 5'd0, 5'd8, 5'd1, 5'd17, 5'd2, 5'd9};
    localparam logic [POS_W-1:0] FWD_II [LETTERS] = '{
        5'd0, 5'd9, 5'd3, 5'd10, 5'd18, 5'd8, 5'd17, 5'd20, 5'd23, 5'd1, 5'd11, 5'd7, 5'd22,
        5'd19, 5'd12, 5'd2, 5'd16, 5'd6, 5'd25, 5'd13, 5'd15, 5'd24, 5'd5, 5'd21, 5'd14, 5'd4};
    localparam logic [POS_W-1:0] FWD_III [LETTERS] = '{
        5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd2, 5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
        5'd13, 5'd24, 5'd4, 5'd8, 5'd22, 5'd6, 5'd0, 5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14};

    localparam logic [POS_W-1:0] INV_I [LETTERS] = '{
        5'd20, 5'd22, 5'd24, 5'd6, 5'd0, 5'd3, 5'd5, 5'd15, 5'd21, 5'd25, 5'd1, 5'd4, 5'd2,
        5'd10, 5'd12, 5'd19, 5'd7, 5'd23, 5'd18, 5'd11, 5'd17, 5'd8, 5'd13, 5'd16, 5'd14, 5'd9};
    localparam logic [POS_W-1:0] INV_II [LETTERS] = '{
        5'd0, 5'd9, 5'd15, 5'd2, 5'd25, 5'd22, 5'd17, 5'd11, 5'd5, 5'd1, 5'd3, 5'd10, 5'd14,
        5'd19, 5'd24, 5'd20, 5'd16, 5'd6, 5'd4, 5'd13, 5'd7, 5'd23, 5'd12, 5'd8, 5'd21, 5'd18};
    localparam logic [POS_W-1:0] INV_III [LETTERS] = '{
        5'd19, 5'd0, 5'd6, 5'd1, 5'd15, 5'd2, 5'd18, 5'd3, 5'd16, 5'd4, 5'd20, 5'd5, 5'd21,
        5'd13, 5'd25, 5'd7, 5'd24, 5'd8, 5'd23, 5'd9, 5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12};

    // Both operands are assumed already reduced to 0..25, so one correction suffices.
    function automatic logic [POS_W-1:0] mod_add(input logic [POS_W-1:0] a,
                                                 input logic [POS_W-1:0] b);
        logic [POS_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, LETTERS_W}) begin
            s = s - {1'b0, LETTERS_W};
        end
        return s[POS_W-1:0];
    endfunction

    function automatic logic [POS_W-1:0] mod_sub(input logic [POS_W-1:0] a,
                                                 input logic [POS_W-1:0] b);
        if (a >= b) begin
            return a - b;
        end
        return a + LETTERS_W - b;
    endfunction

    function automatic letter_t onehot_to_idx(input logic [LETTERS-1:0] oh);
        letter_t r;
        int      cnt;
        r   = '0;
        cnt = 0;
        for (int i = 0; i < LETTERS; i++) begin
            if (oh[i]) begin
                r.idx = POS_W'(i);
                cnt   = cnt + 1;
            end
        end
        r.valid = (cnt == 1);
        return r;
    endfunction

    function automatic logic [LETTERS-1:0] idx_to_onehot(input logic [POS_W-1:0] idx);
        logic [LETTERS-1:0] oh;
        oh = '0;
        if (idx < LETTERS_W) begin
            oh[idx] = 1'b1;
        end
        return oh;
    endfunction

    function automatic logic [POS_W-1:0] fwd_lookup(input logic [1:0] cfg,
                                                    input logic [POS_W-1:0] c);
        logic [POS_W-1:0] w;
        w = c;
        if (c < LETTERS_W) begin
            case (cfg_e'(cfg))
                CFG_ROTOR_I:   w = FWD_I[c];
                CFG_ROTOR_II:  w = FWD_II[c];
                CFG_ROTOR_III: w = FWD_III[c];
                default:       w = c;
            endcase
        end
        return w;
    endfunction

endpackage

// File: rtl/rotor_inv_wiring.sv
// Combinational inverse-wiring lookup (contact c -> contact w) for the selected rotor.
module rotor_inv_wiring
    import enigma_pkg::*;
(
    input  logic [1:0]       cfg,
    input  logic [POS_W-1:0] c,
    output logic [POS_W-1:0] w
);

    always_comb begin
        w = c;
        if (c < LETTERS_W) begin
            case (cfg_e'(cfg))
                CFG_ROTOR_I:   w = INV_I[c];
                CFG_ROTOR_II:  w = INV_II[c];
                CFG_ROTOR_III: w = INV_III[c];
                default:       w = c;
            endcase
        end
    end

endmodule

// File: rtl/rotor_return.sv
// Return-path Enigma rotor stage: inverse wiring with rotational offset, 1-cycle latency.
// Optional ring setting input is enabled by defining ROTOR_RING_SETTING_EN.
module rotor_return
    import enigma_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               in_valid,
    input  logic [LETTERS-1:0] in_char,
    input  logic [1:0]         wiring_config,
    input  logic               load,
    input  logic [POS_W-1:0]   load_pos,
    input  logic               step,
`ifdef ROTOR_RING_SETTING_EN
    input  logic [POS_W-1:0]   ring_pos,
`endif
    output logic               out_valid,
    output logic [LETTERS-1:0] out_char,
    output logic [POS_W-1:0]   position,
    output logic               notch
);

    logic [POS_W-1:0]   pos_q, pos_d;
    logic               out_valid_q, out_valid_d;
    logic [LETTERS-1:0] out_char_q, out_char_d;

    letter_t            dec;
    logic [POS_W-1:0]   offset;
    logic [POS_W-1:0]   wire_in;
    logic [POS_W-1:0]   wire_out;
    logic [POS_W-1:0]   out_idx;
`ifdef ROTOR_RING_SETTING_EN
    logic [POS_W-1:0]   ring_eff;
`endif

    // Load wins over step; out-of-range load values snap to position 0.
    always_comb begin
        pos_d = pos_q;
        if (load) begin
            pos_d = (load_pos < LETTERS_W) ? load_pos : '0;
        end else if (step) begin
            pos_d = mod_add(pos_q, POS_W'(1));
        end
    end

    always_comb begin
`ifdef ROTOR_RING_SETTING_EN
        ring_eff = (ring_pos < LETTERS_W) ? ring_pos : '0;
        offset   = mod_sub(pos_q, ring_eff);
`else
        offset   = pos_q;
`endif
        dec     = onehot_to_idx(in_char);
        wire_in = mod_add(dec.idx, offset);
    end

    rotor_inv_wiring u_inv_wiring (
        .cfg (wiring_config),
        .c   (wire_in),
        .w   (wire_out)
    );

    // Malformed input still produces a valid beat, but with an all-zero letter.
    always_comb begin
        out_idx     = mod_sub(wire_out, offset);
        out_valid_d = in_valid;
        out_char_d  = out_char_q;
        if (in_valid) begin
            out_char_d = dec.valid ? idx_to_onehot(out_idx) : '0;
        end
    end

    always_comb begin
        case (cfg_e'(wiring_config))
            CFG_ROTOR_I:   notch = (pos_q == NOTCH_I);
            CFG_ROTOR_II:  notch = (pos_q == NOTCH_II);
            CFG_ROTOR_III: notch = (pos_q == NOTCH_III);
            default:       notch = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pos_q       <= '0;
            out_valid_q <= 1'b0;
            out_char_q  <= '0;
        end else begin
            pos_q       <= pos_d;
            out_valid_q <= out_valid_d;
            out_char_q  <= out_char_d;
        end
    end

    assign position  = pos_q;
    assign out_valid = out_valid_q;
    assign out_char  = out_char_q;

endmodule

// File: tb/tb_rotor_return.sv
// Testbench for rotor_return: directed cases plus randomized traffic, scored against
// a letter-level Enigma model built from the rotor wiring strings.
module tb_rotor_return;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic [25:0] in_char;
    logic [1:0]  wiring_config;
    logic        load;
    logic [4:0]  load_pos;
    logic        step;
`ifdef ROTOR_RING_SETTING_EN
    logic [4:0]  ring_pos;
`endif
    logic        out_valid;
    logic [25:0] out_char;
    logic [4:0]  position;
    logic        notch;

    typedef struct {
        logic [25:0] exp;
        int          in_idx;
        int          cfg;
        int          off;
    } sb_t;

    sb_t   sb_q[$];
    int    checks = 0;
    int    errors = 0;
    int    model_pos = 0;

    string inv_tab [3] = '{"UWYGADFPVZBECKMTHXSLRINQOJ",
                           "AJPCZWRLFBDKOTYUQGENHXMIVS",
                           "TAGBPCSDQEUFVNZHYIXJWLRKOM"};
    string fwd_tab [3] = '{"EKMFLGDQVZNTOWYHXUSPAIBRCJ",
                           "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                           "BDFHJLCPRTXVZNYEIWGAKMUSQO"};

    always #5 clk = ~clk;

    rotor_return dut (
        .clk           (clk),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_char       (in_char),
        .wiring_config (wiring_config),
        .load          (load),
        .load_pos      (load_pos),
        .step          (step),
`ifdef ROTOR_RING_SETTING_EN
        .ring_pos      (ring_pos),
`endif
        .out_valid     (out_valid),
        .out_char      (out_char),
        .position      (position),
        .notch         (notch)
    );

    function automatic int idx_of(input logic [25:0] v);
        for (int i = 0; i < 26; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic int ring_eff();
`ifdef ROTOR_RING_SETTING_EN
        return (ring_pos < 5'd26) ? int'(ring_pos) : 0;
`else
        return 0;
`endif
    endfunction

    function automatic logic [25:0] model_out(input logic [25:0] ch, input int cfg, input int off);
        logic [25:0] r;
        int c, w, o;
        r = '0;
        if ($countones(ch) != 1) return r;
        c = (idx_of(ch) + off) % 26;
        if (cfg == 3) w = c;
        else w = int'(inv_tab[cfg][c]) - 65;
        o = (w - off + 26) % 26;
        r[o] = 1'b1;
        return r;
    endfunction

    function automatic int model_fwd(input int i, input int cfg, input int off);
        int c, w;
        c = (i + off) % 26;
        w = int'(fwd_tab[cfg][c]) - 65;
        return (w - off + 26) % 26;
    endfunction

    function automatic logic model_notch(input int cfg, input int p);
        return (cfg == 0 && p == 17) || (cfg == 1 && p == 5) || (cfg == 2 && p == 22);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the expected letter is queued before the capturing edge.
    task automatic applyStimulus(input logic v, input logic [25:0] ch, input logic [1:0] cfg,
                                 input logic ld, input logic [4:0] lp, input logic st);
        sb_t e;
        @(negedge clk);
        in_valid      = v;
        in_char       = ch;
        wiring_config = cfg;
        load          = ld;
        load_pos      = lp;
        step          = st;
        if (v) begin
            e.off    = (model_pos - ring_eff() + 26) % 26;
            e.cfg    = int'(cfg);
            e.exp    = model_out(ch, e.cfg, e.off);
            e.in_idx = ($countones(ch) == 1) ? idx_of(ch) : -1;
            sb_q.push_back(e);
        end
        if (ld) model_pos = (lp < 5'd26) ? int'(lp) : 0;
        else if (st) model_pos = (model_pos + 1) % 26;
        @(posedge clk);
        #1;
        checkOutput("position", 32'(position), 32'(model_pos));
        checkOutput("notch", 32'(notch), 32'(model_notch(int'(cfg), model_pos)));
        checkOutput("out_valid", 32'(out_valid), 32'(v));
        in_valid = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a letter.
    always begin
        sb_t e;
        @(posedge clk);
        #1;
        if (resetn && out_valid) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("out_char", 32'(out_char), 32'(e.exp));
                if (e.cfg < 3 && e.in_idx >= 0 && $countones(out_char) == 1) begin
                    checkOutput("round_trip", 32'(model_fwd(idx_of(out_char), e.cfg, e.off)),
                                32'(e.in_idx));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [25:0] ch;
        int a, b;
        resetn        = 1'b0;
        in_valid      = 1'b0;
        in_char       = '0;
        wiring_config = 2'b00;
        load          = 1'b0;
        load_pos      = '0;
        step          = 1'b0;
`ifdef ROTOR_RING_SETTING_EN
        ring_pos      = '0;
`endif
        repeat (2) @(negedge clk);
        checkOutput("reset_position", 32'(position), 32'd0);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_char", 32'(out_char), 32'd0);
        checkOutput("reset_notch", 32'(notch), 32'd0);
        resetn = 1'b1;

        applyStimulus(1'b1, 26'd1, 2'b00, 1'b0, 5'd0, 1'b0);
        checkOutput("a_to_u", 32'(out_char), 32'(26'd1 << 20));
        applyStimulus(1'b0, 26'd5, 2'b00, 1'b0, 5'd0, 1'b0);
        checkOutput("hold_out_char", 32'(out_char), 32'(26'd1 << 20));

        applyStimulus(1'b0, 26'd0, 2'b00, 1'b1, 5'd1, 1'b0);
        applyStimulus(1'b1, 26'd1, 2'b00, 1'b0, 5'd0, 1'b0);
        checkOutput("a_to_v_pos1", 32'(out_char), 32'(26'd1 << 21));

        applyStimulus(1'b0, 26'd0, 2'b00, 1'b1, 5'd25, 1'b0);
        applyStimulus(1'b0, 26'd0, 2'b00, 1'b0, 5'd0, 1'b1);
        checkOutput("wrap_to_0", 32'(position), 32'd0);
        applyStimulus(1'b0, 26'd0, 2'b00, 1'b1, 5'd7, 1'b1);
        checkOutput("load_over_step", 32'(position), 32'd7);
        applyStimulus(1'b0, 26'd0, 2'b00, 1'b1, 5'd30, 1'b0);
        checkOutput("load_oob", 32'(position), 32'd0);

        applyStimulus(1'b0, 26'd0, 2'b01, 1'b1, 5'd4, 1'b0);
        applyStimulus(1'b0, 26'd0, 2'b01, 1'b0, 5'd0, 1'b1);
        checkOutput("notch_ii", 32'(notch), 32'd1);
        applyStimulus(1'b0, 26'd0, 2'b10, 1'b0, 5'd0, 1'b0);
        checkOutput("notch_cfg_switch", 32'(notch), 32'd0);
        applyStimulus(1'b0, 26'd0, 2'b10, 1'b1, 5'd22, 1'b0);
        checkOutput("notch_iii", 32'(notch), 32'd1);

        applyStimulus(1'b1, 26'h3, 2'b00, 1'b0, 5'd0, 1'b0);
        checkOutput("multi_hot", 32'(out_char), 32'd0);
        applyStimulus(1'b1, 26'h0, 2'b00, 1'b0, 5'd0, 1'b0);
        checkOutput("zero_hot", 32'(out_char), 32'd0);

        applyStimulus(1'b0, 26'd0, 2'b00, 1'b1, 5'd3, 1'b0);
        applyStimulus(1'b1, 26'd1 << 9, 2'b00, 1'b0, 5'd0, 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("async_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("async_rst_out_char", 32'(out_char), 32'd0);
        checkOutput("async_rst_position", 32'(position), 32'd0);
        sb_q.delete();
        model_pos = 0;
        @(negedge clk);
        resetn = 1'b1;

`ifdef ROTOR_RING_SETTING_EN
        ring_pos = 5'd1;
        applyStimulus(1'b0, 26'd0, 2'b00, 1'b1, 5'd1, 1'b0);
        applyStimulus(1'b1, 26'd1, 2'b00, 1'b0, 5'd0, 1'b0);
        checkOutput("ring_a_to_u", 32'(out_char), 32'(26'd1 << 20));
        ring_pos = 5'd0;
`endif

        for (int n = 0; n < 400; n++) begin
            a = $urandom_range(0, 25);
            b = (a + $urandom_range(1, 25)) % 26;
            ch = '0;
            case ($urandom_range(0, 9))
                0:       ch = '0;
                1:       begin ch[a] = 1'b1; ch[b] = 1'b1; end
                default: ch[a] = 1'b1;
            endcase
`ifdef ROTOR_RING_SETTING_EN
            ring_pos = 5'($urandom_range(0, 31));
`endif
            applyStimulus(1'($urandom_range(0, 3) != 0), ch, 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 7) == 0), 5'($urandom_range(0, 31)),
                          1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        checkOutput("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
